// File: rtl/seq_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tx_pkg
//  Description : Shared types, constants and helpers for the serial pattern
//                transmitter (state encoding, length clamp, gap counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_tx_pkg;

    // Transmitter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    // Width of the idle-gap counter; GAP_BITS must not exceed 2**c_gap_cnt_w
    localparam int c_gap_cnt_w = 8;

    // A requested length of 0, or one larger than the register, means "full width"
    function automatic int clamp_len(input int len, input int width);
        if ((len == 0) || (len > width)) begin
            return width;
        end
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_tx_piso.sv
`default_nettype none
// ============================================================================
//  Module      : seq_tx_piso
//  Description : Parallel-load, LSB-first shift register. Load has priority
//                over shift; the register clears asynchronously on rst.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_tx_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_shreg;

    // Load a new word or move the next bit down into position 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (i_load) begin
            r_shreg <= i_data;
        end else if (i_shift) begin
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
        end
    end

    assign o_lsb = r_shreg[0];

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pattern_tx
//  Description : Serial pattern transmitter. Captures a pattern, length and
//                repeat count on a valid/ready handshake, then shifts the
//                pattern out LSB-first with an idle gap after every frame and
//                a one-cycle done pulse at the end. All outputs come from
//                registers only.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LEN_W    = 4,
    parameter int GAP_BITS = 2,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    // Last value the gap counter reaches before leaving GAP
    localparam logic [c_gap_cnt_w-1:0] c_gap_last =
        (GAP_BITS == 0) ? '0 : c_gap_cnt_w'(GAP_BITS - 1);

    tx_state_t              r_state;
    logic [WIDTH-1:0]       r_pattern;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_bit_cnt;
    logic [CNT_W-1:0]       r_rep_cnt;
    logic [c_gap_cnt_w-1:0] r_gap_cnt;
    logic                   r_ser_valid;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_accept;
    logic                   w_bit_last;
    logic                   w_gap_last;
    logic                   w_more;
    logic                   w_restart;
    logic                   w_piso_load;
    logic                   w_piso_shift;
    logic [WIDTH-1:0]       w_piso_data;
    logic                   w_lsb;

    // Handshake, frame-boundary and shift-register control decode
    always_comb begin
        w_accept     = (r_state == IDLE) && start_valid && !abort;
        w_bit_last   = (r_bit_cnt == (r_len - LEN_W'(1)));
        w_gap_last   = (r_gap_cnt == c_gap_last);
        w_more       = (r_rep_cnt != '0);
        w_restart    = 1'b0;
        if (!abort && w_more) begin
            if ((r_state == SHIFT) && w_bit_last && (GAP_BITS == 0)) begin
                w_restart = 1'b1;
            end
            if ((r_state == GAP) && w_gap_last) begin
                w_restart = 1'b1;
            end
        end
        w_piso_load  = w_accept || w_restart;
        w_piso_shift = (r_state == SHIFT) && !w_bit_last && !abort;
        // A fresh request loads straight from the port; repeats reload the stored copy
        w_piso_data  = w_accept ? pattern : r_pattern;
    end

    seq_tx_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_piso_load),
        .i_shift (w_piso_shift),
        .i_data  (w_piso_data),
        .o_lsb   (w_lsb)
    );

    // Control FSM with the three counters and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pattern   <= '0;
            r_len       <= '0;
            r_bit_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort && (r_state != IDLE)) begin
            // Cancel outright: no done pulse, straight back to IDLE
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_rep_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pattern   <= pattern;
                        r_len       <= LEN_W'(clamp_len(32'(len), WIDTH));
                        r_rep_cnt   <= repeat_n;
                        r_bit_cnt   <= '0;
                        r_gap_cnt   <= '0;
                        r_state     <= SHIFT;
                        r_ser_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_bit_last) begin
                        r_bit_cnt <= '0;
                        if (GAP_BITS != 0) begin
                            r_state     <= GAP;
                            r_gap_cnt   <= '0;
                            r_ser_valid <= 1'b0;
                        end else if (w_more) begin
                            // Next frame follows immediately, stay in SHIFT
                            r_rep_cnt <= r_rep_cnt - CNT_W'(1);
                        end else begin
                            r_state     <= DONE;
                            r_ser_valid <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + LEN_W'(1);
                    end
                end
                GAP: begin
                    if (w_gap_last) begin
                        r_gap_cnt <= '0;
                        if (w_more) begin
                            r_rep_cnt   <= r_rep_cnt - CNT_W'(1);
                            r_state     <= SHIFT;
                            r_ser_valid <= 1'b1;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_gap_cnt_w'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_ser_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    // Data bit is only presented while a pattern bit is valid
    assign ser_out     = r_ser_valid & w_lsb;
    assign ser_valid   = r_ser_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign start_ready = (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_pattern_tx
//  Description : Scoreboard bench for seq_pattern_tx. Instance A uses a
//                two-cycle gap, instance B uses no gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    localparam int ALL = 1000;

    typedef struct {
        bit is_done;
        bit val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic       a_start = 1'b0, a_abort = 1'b0;
    logic [7:0] a_pattern = '0;
    logic [3:0] a_len = '0, a_repeat = '0;
    logic       a_ready, a_ser_out, a_ser_valid, a_busy, a_done;

    logic       b_start = 1'b0, b_abort = 1'b0;
    logic [7:0] b_pattern = '0;
    logic [3:0] b_len = '0, b_repeat = '0;
    logic       b_ready, b_ser_out, b_ser_valid, b_busy, b_done;

    ev_t qa[$];
    ev_t qb[$];
    ev_t ev_a, ev_b;

    int n_vec = 0;
    int n_err = 0;

    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_BITS(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .start_valid(a_start), .start_ready(a_ready),
        .pattern(a_pattern), .len(a_len), .repeat_n(a_repeat), .abort(a_abort),
        .ser_out(a_ser_out), .ser_valid(a_ser_valid), .busy(a_busy), .done(a_done)
    );

    seq_pattern_tx #(.WIDTH(8), .LEN_W(4), .GAP_BITS(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start_valid(b_start), .start_ready(b_ready),
        .pattern(b_pattern), .len(b_len), .repeat_n(b_repeat), .abort(b_abort),
        .ser_out(b_ser_out), .ser_valid(b_ser_valid), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected stream: frame f, bit i appears in cycle n + f*(L+G) + i; done after the last gap
    function automatic void push_frames(input bit to_b, input logic [7:0] pat, input int l_eff,
                                        input int rep, input int gap, input int n,
                                        input int nbits, input bit with_done);
        ev_t e;
        int  cnt;
        cnt = 0;
        for (int f = 0; f <= rep; f++) begin
            for (int i = 0; i < l_eff; i++) begin
                if (cnt < nbits) begin
                    e.is_done = 1'b0;
                    e.val     = pat[i];
                    e.cyc     = n + f * (l_eff + gap) + i;
                    if (to_b) qb.push_back(e); else qa.push_back(e);
                end
                cnt++;
            end
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.val     = 1'b0;
            e.cyc     = n + (l_eff + gap) * (rep + 1);
            if (to_b) qb.push_back(e); else qa.push_back(e);
        end
    endfunction

    task automatic start_tx(input bit to_b, input logic [7:0] pat, input logic [3:0] l,
                            input logic [3:0] r, input int nbits, input bit with_done,
                            output int n);
        int le;
        le = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
        @(negedge clk);
        if (to_b) begin
            b_pattern = pat; b_len = l; b_repeat = r; b_start = 1'b1;
        end else begin
            a_pattern = pat; a_len = l; a_repeat = r; a_start = 1'b1;
        end
        n = cyc + 1;
        push_frames(to_b, pat, le, int'(r), to_b ? 0 : 2, n, nbits, with_done);
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor A: every valid bit or done pulse must match the head of the queue
    always @(negedge clk) begin
        if (!rst && (a_ser_valid || a_done)) begin
            if (qa.size() == 0) begin
                check("A unexpected output", 1, 0);
            end else begin
                ev_a = qa.pop_front();
                check("A kind", int'(a_done), int'(ev_a.is_done));
                if (!ev_a.is_done) check("A bit", int'(a_ser_out), int'(ev_a.val));
                check("A cycle", cyc, ev_a.cyc);
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst && (b_ser_valid || b_done)) begin
            if (qb.size() == 0) begin
                check("B unexpected output", 1, 0);
            end else begin
                ev_b = qb.pop_front();
                check("B kind", int'(b_done), int'(ev_b.is_done));
                if (!ev_b.is_done) check("B bit", int'(b_ser_out), int'(ev_b.val));
                check("B cycle", cyc, ev_b.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst A ser_valid", int'(a_ser_valid), 0);
        check("rst A busy", int'(a_busy), 0);
        check("rst A start_ready", int'(a_ready), 1);
        check("rst B start_ready", int'(b_ready), 1);
        rst = 1'b0;

        // Reset asserted asynchronously in the middle of a frame
        start_tx(1'b0, 8'hFF, 4'd8, 4'd0, 3, 1'b0, n);
        wait_cyc(n + 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst ser_valid", int'(a_ser_valid), 0);
        check("async rst ser_out", int'(a_ser_out), 0);
        check("async rst busy", int'(a_busy), 0);
        check("async rst done", int'(a_done), 0);
        check("async rst start_ready", int'(a_ready), 1);
        @(negedge clk);
        #1 rst = 1'b0;

        // Basic full-width frame
        start_tx(1'b0, 8'b1011_0010, 4'd8, 4'd0, ALL, 1'b1, n);
        check("basic busy c1", int'(a_busy), 1);
        check("basic start_ready c1", int'(a_ready), 0);
        wait_cyc(n + 10);
        check("basic busy c11", int'(a_busy), 1);
        wait_cyc(n + 11);
        check("basic start_ready c12", int'(a_ready), 1);
        check("basic busy c12", int'(a_busy), 0);

        // Short frame repeated three times
        start_tx(1'b0, 8'b0000_1011, 4'd4, 4'd2, ALL, 1'b1, n);
        wait_cyc(n + 19);

        // No-gap instance: clamp of len=0 and len=12, plus a short frame
        start_tx(1'b1, 8'hA5, 4'd0, 4'd1, ALL, 1'b1, n);
        wait_cyc(n + 17);
        start_tx(1'b1, 8'h3C, 4'd12, 4'd0, ALL, 1'b1, n);
        wait_cyc(n + 9);
        start_tx(1'b1, 8'h06, 4'd3, 4'd1, ALL, 1'b1, n);
        wait_cyc(n + 7);

        // Abort on the third bit of the second frame
        start_tx(1'b0, 8'h5A, 4'd8, 4'd2, 11, 1'b0, n);
        wait_cyc(n + 12);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        check("abort ser_valid", int'(a_ser_valid), 0);
        check("abort busy", int'(a_busy), 0);
        check("abort done", int'(a_done), 0);
        check("abort start_ready", int'(a_ready), 1);

        // Abort together with a request while idle: nothing is accepted
        a_pattern = 8'hFF; a_len = 4'd8; a_repeat = 4'd0;
        a_abort = 1'b1; a_start = 1'b1;
        @(negedge clk);
        a_abort = 1'b0; a_start = 1'b0;
        check("idle abort busy", int'(a_busy), 0);
        check("idle abort start_ready", int'(a_ready), 1);
        repeat (4) @(negedge clk);

        // Request held high while the pattern changes mid-frame
        @(negedge clk);
        a_pattern = 8'hC3; a_len = 4'd8; a_repeat = 4'd0; a_start = 1'b1;
        n = cyc + 1;
        push_frames(1'b0, 8'hC3, 8, 0, 2, n, ALL, 1'b1);
        wait_cyc(n + 3);
        a_pattern = 8'h3C;
        n2 = n + 12;
        push_frames(1'b0, 8'h3C, 8, 0, 2, n2, ALL, 1'b1);
        wait_cyc(n + 11);
        check("held start_ready idle", int'(a_ready), 1);
        wait_cyc(n2);
        a_start = 1'b0;
        check("held second accepted", int'(a_busy), 1);
        wait_cyc(n2 + 14);

        check("A queue drained", qa.size(), 0);
        check("B queue drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It generates the single-bit stimulus stream that the team's Moore-style serial sequence detectors consume. A host loads a pattern, a length and a repeat count through a valid/ready handshake. The block then shifts the pattern out LSB-first, one bit per clock, with a fixed idle gap after each frame, and pulses done when the last frame is finished.

Parameters:
WIDTH, 8, maximum pattern length in bits
LEN_W, 4, width of len port; must hold the value WIDTH
GAP_BITS, 2, idle cycles (ser_out=0, ser_valid=0) after each frame; 0 = no gap
CNT_W, 4, width of repeat_n port

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  reset, asynchronous, active-high
start_valid  in  1  host request to transmit
start_ready  out  1  high only in IDLE
pattern  in  WIDTH  bits to send; bit 0 is sent first
len  in  LEN_W  number of bits per frame; 0 or a value above WIDTH means WIDTH
repeat_n  in  CNT_W  frame count minus 1; total frames = repeat_n+1
abort  in  1  cancel the current transmission
ser_out  out  1  serial data, registered
ser_valid  out  1  high while ser_out carries a pattern bit
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; ser_out=0, ser_valid=0, busy=0, done=0; start_ready=1.
  - Captured pattern, bit counter and repeat counter are cleared.
- States: IDLE, SHIFT, GAP, DONE.
- Acceptance:
  - Happens when start_valid && start_ready are high at rising edge t0.
  - pattern, len (after clamping) and repeat_n are captured at t0. Later input changes have no effect until the next acceptance.
- SHIFT:
  - ser_out=captured pattern[i] and ser_valid=1 in the cycles after edges t0..t0+len-1, for i=0..len-1.
  - busy=1 from the cycle after t0.
- GAP:
  - Runs GAP_BITS cycles after the last bit of each frame, including the final frame.
  - ser_out=0, ser_valid=0, busy=1.
  - If GAP_BITS=0, SHIFT goes directly to the next frame or to DONE.
- Repeat:
  - After the gap, if frames remain, the next frame starts in the following cycle.
  - The stream restarts from the captured pattern bit 0 (the stored pattern is not consumed).
  - Frames are back-to-back apart from the gap.
- DONE:
  - Lasts one cycle with done=1, busy=1, ser_valid=0. The next cycle is IDLE with start_ready=1.
  - Total: done is high in the cycle after edge t0+(len+GAP_BITS)*(repeat_n+1).
- start_valid while busy is ignored; there is no queueing.
- abort:
  - Sampled at the rising edge, with priority over every other transition.
  - From any non-IDLE state, the next cycle is IDLE with all outputs 0 and no done pulse.
  - abort in IDLE has no effect.
  - abort and start_valid in the same IDLE cycle: abort wins and nothing is accepted.
- All outputs are Moore outputs, decoded only from registered state, shift register and counters. There is no combinational path from any input to any output.
- Counters:
  - Bit counter is LEN_W wide and counts 0..len-1.
  - Repeat counter is CNT_W wide and counts down from repeat_n to 0.
  - Neither counter may wrap during a transmission.

Decomposition:
- Shared package seq_tx_pkg contains:
  - the state enum (IDLE, SHIFT, GAP, DONE) as a 2-bit typedef;
  - the len-clamp rule as a function;
  - the gap-width constant used to size the gap counter.
- One natural sub-module: seq_tx_piso.
  - WIDTH-bit parallel-load, LSB-first shift register with load/shift enables and an asynchronous active-high clear.
  - The FSM and the three counters stay in seq_pattern_tx.

Test Plan:
1. Reset asserted mid-SHIFT (asynchronously, between edges) -> outputs go to 0 immediately; start_ready=1; a fresh start afterwards behaves normally.
2. Basic frame: pattern=8'b1011_0010, len=8, repeat_n=0, GAP_BITS=2 -> ser_out=0,1,0,0,1,1,0,1 with ser_valid=1 for 8 cycles; 2 gap cycles; done in cycle 11 after acceptance; start_ready=1 in cycle 12.
3. Short frame with repeat: pattern=8'b0000_1011, len=4, repeat_n=2 -> three frames of 1,1,0,1, each followed by 2 gap cycles; done in cycle 19 after acceptance; exactly 12 ser_valid cycles.
4. Clamp and no-gap build: GAP_BITS=0, len=0, repeat_n=1, pattern=8'hA5 -> two back-to-back frames of 1,0,1,0,0,1,0,1; done in cycle 17.
5. Abort on the 3rd bit of frame 2 -> next cycle IDLE; ser_valid=0, busy=0; done never pulses. Also: abort and start_valid together in IDLE -> no acceptance.
6. start_valid held high throughout, with pattern changing mid-transmission -> the captured pattern is unaffected; the second request is accepted in the first IDLE cycle after DONE.
